// File: rtl/lcd_i2c_seq.sv
// lcd_i2c_seq: feeds an i2c_master command/data stream to run an HD44780 LCD behind
// a PCF8574 expander in 4-bit mode, including the autonomous power-on initialisation.
module lcd_i2c_seq #(
    parameter int unsigned CLK_HZ   = 12000000,
    parameter logic [6:0]  DEV_ADDR = 7'h27,
    parameter logic [15:0] PRESCALE = 16'd30,
    parameter int unsigned PWRUP_US = 50000,
    parameter int unsigned LONG_US  = 5000,
    parameter int unsigned SHORT_US = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_rs,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        backlight,
    output logic        init_done,
    output logic        busy,
    output logic        error,
    output logic [6:0]  cmd_address,
    output logic        cmd_start,
    output logic        cmd_read,
    output logic        cmd_write,
    output logic        cmd_write_multiple,
    output logic        cmd_stop,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  data_tdata,
    output logic        data_tvalid,
    input  logic        data_tready,
    output logic        data_tlast,
    output logic        rd_tready,
    output logic [15:0] prescale,
    output logic        stop_on_idle,
    input  logic        i2c_busy,
    input  logic        missed_ack
);
    function automatic logic [31:0] us_to_cyc(input longint unsigned us);
        longint unsigned c;
        c = us * 64'(CLK_HZ) / 64'd1000000;
        return (c == 64'd0) ? 32'd1 : c[31:0];
    endfunction

    localparam logic [31:0] PWRUP_CYC = us_to_cyc(64'(PWRUP_US));
    localparam logic [31:0] LONG_CYC  = us_to_cyc(64'(LONG_US));
    localparam logic [31:0] SHORT_CYC = us_to_cyc(64'(SHORT_US));

    // Expander byte {D7..D4, BL, EN, RW, RS}; odd index drops EN, index bit 1 picks the low nibble.
    function automatic logic [7:0] xbyte(input logic [7:0] b, input logic [1:0] i, input logic bl, input logic rs);
        return {i[1] ? b[3:0] : b[7:4], bl, ~i[0], 1'b0, rs};
    endfunction

    typedef enum logic [2:0] {PWRUP, INIT, IDLE, CMD, DATA, DRAIN, DELAY} state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  step_q, step_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  byte_q, byte_d;
    logic [7:0]  tdata_q, tdata_d;
    logic        rs_q, rs_d;
    logic        nib_q, nib_d;
    logic        seen_q, seen_d;
    logic        init_done_q, init_done_d;
    logic        error_q, error_d;
    logic [7:0]  init_byte;
    logic        long_sel;
    logic [31:0] dly;

    assign init_byte = step_q <= 3'd2 ? 8'h30 :
                       step_q == 3'd3 ? 8'h20 :
                       step_q == 3'd4 ? 8'h28 :
                       step_q == 3'd5 ? 8'h0C :
                       step_q == 3'd6 ? 8'h06 : 8'h01;
    // Init nibbles carry their value in the high half; only the first one needs the long wait.
    assign long_sel = nib_q ? (step_q == 3'd0) :
                      (!rs_q && (byte_q == 8'h01 || byte_q == 8'h02 || byte_q == 8'h03));
    assign dly = long_sel ? LONG_CYC : SHORT_CYC;

    assign cmd_address        = DEV_ADDR;
    assign cmd_start          = 1'b0;
    assign cmd_read           = 1'b0;
    assign cmd_write          = 1'b0;
    assign cmd_write_multiple = 1'b1;
    assign cmd_stop           = 1'b1;
    assign stop_on_idle       = 1'b0;
    assign prescale           = PRESCALE;
    assign rd_tready          = 1'b1;
    assign cmd_valid          = state_q == CMD;
    assign data_tvalid        = state_q == DATA;
    assign data_tlast         = state_q == DATA && idx_q == (nib_q ? 2'd1 : 2'd3);
    assign data_tdata         = tdata_q;
    assign in_ready           = state_q == IDLE && init_done_q;
    assign busy               = state_q != IDLE;
    assign init_done          = init_done_q;
    assign error              = error_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= PWRUP;
            cnt_q       <= '0;
            step_q      <= '0;
            idx_q       <= '0;
            byte_q      <= '0;
            tdata_q     <= '0;
            rs_q        <= 1'b0;
            nib_q       <= 1'b0;
            seen_q      <= 1'b0;
            init_done_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            idx_q       <= idx_d;
            byte_q      <= byte_d;
            tdata_q     <= tdata_d;
            rs_q        <= rs_d;
            nib_q       <= nib_d;
            seen_q      <= seen_d;
            init_done_q <= init_done_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        step_d      = step_q;
        idx_d       = idx_q;
        byte_d      = byte_q;
        tdata_d     = tdata_q;
        rs_d        = rs_q;
        nib_d       = nib_q;
        seen_d      = seen_q | (i2c_busy && (state_q == DATA || state_q == DRAIN));
        init_done_d = init_done_q;
        error_d     = error_q | missed_ack;
        case (state_q)
            PWRUP: begin
                cnt_d   = cnt_q == PWRUP_CYC - 32'd1 ? '0 : cnt_q + 32'd1;
                state_d = cnt_q == PWRUP_CYC - 32'd1 ? INIT : PWRUP;
            end
            INIT: begin
                byte_d  = init_byte;
                rs_d    = 1'b0;
                nib_d   = !step_q[2];
                state_d = CMD;
            end
            IDLE: if (in_valid && in_ready) begin
                byte_d  = in_data;
                rs_d    = in_rs;
                nib_d   = 1'b0;
                state_d = CMD;
            end
            CMD: if (cmd_ready) begin
                idx_d   = 2'd0;
                seen_d  = 1'b0;
                tdata_d = xbyte(byte_q, 2'd0, backlight, rs_q);
                state_d = DATA;
            end
            DATA: if (data_tready) begin
                if (data_tlast) state_d = DRAIN;
                else begin
                    idx_d   = idx_q + 2'd1;
                    tdata_d = xbyte(byte_q, idx_q + 2'd1, backlight, rs_q);
                end
            end
            DRAIN: if (seen_q && !i2c_busy) begin
                cnt_d   = '0;
                state_d = DELAY;
            end
            DELAY: if (cnt_q == dly - 32'd1) begin
                cnt_d = '0;
                if (init_done_q) state_d = IDLE;
                else if (step_q == 3'd7) begin
                    init_done_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    step_d  = step_q + 3'd1;
                    state_d = INIT;
                end
            end else cnt_d = cnt_q + 32'd1;
            default: state_d = PWRUP;
        endcase
    end
endmodule

// File: tb/tb_lcd_i2c_seq.sv
// tb_lcd_i2c_seq: randomized bench with an i2c_master responder and a byte-stream reference model.
// Instance a uses the test-plan timing; instance b has short delays for the reset/restart scenario.
module tb_lcd_i2c_seq;
    localparam int A_PWRUP = 50000;
    localparam int A_LONG  = 5000;
    localparam int A_SHORT = 100;
    localparam int B_PWRUP = 400;

    logic clk, rst_a, rst_b, sel, bp;
    logic in_valid, in_rs, backlight, missed_ack, cmd_ready, data_tready, i2c_busy;
    logic [7:0] in_data;
    logic a_iv, b_iv;
    logic a_in_ready, a_init_done, a_busy, a_error, a_start, a_read, a_write, a_wm, a_stop, a_cv;
    logic a_tv, a_tl, a_rdy, a_soi;
    logic [6:0] a_addr;
    logic [7:0] a_td;
    logic [15:0] a_pre;
    logic b_in_ready, b_init_done, b_busy, b_error, b_start, b_read, b_write, b_wm, b_stop, b_cv;
    logic b_tv, b_tl, b_rdy, b_soi;
    logic [6:0] b_addr;
    logic [7:0] b_td;
    logic [15:0] b_pre;
    logic m_rst, m_cmd_valid, m_tvalid, m_tlast, m_in_ready, m_init_done, m_busy, m_error;
    logic [7:0] m_tdata;

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int ptr = 0;
    logic [8:0] rx[$];
    logic [8:0] exp_q[$];
    logic [7:0] init_exp [24] = '{8'h3C, 8'h38, 8'h3C, 8'h38, 8'h3C, 8'h38, 8'h2C, 8'h28,
                                  8'h2C, 8'h28, 8'h8C, 8'h88, 8'h0C, 8'h08, 8'hCC, 8'hC8,
                                  8'h0C, 8'h08, 8'h6C, 8'h68, 8'h0C, 8'h08, 8'h1C, 8'h18};

    assign a_iv = in_valid & !sel;
    assign b_iv = in_valid & sel;
    assign m_rst       = sel ? rst_b : rst_a;
    assign m_cmd_valid = sel ? b_cv : a_cv;
    assign m_tvalid    = sel ? b_tv : a_tv;
    assign m_tlast     = sel ? b_tl : a_tl;
    assign m_tdata     = sel ? b_td : a_td;
    assign m_in_ready  = sel ? b_in_ready : a_in_ready;
    assign m_init_done = sel ? b_init_done : a_init_done;
    assign m_busy      = sel ? b_busy : a_busy;
    assign m_error     = sel ? b_error : a_error;

    lcd_i2c_seq #(.CLK_HZ(1000000), .PWRUP_US(A_PWRUP), .LONG_US(A_LONG), .SHORT_US(A_SHORT)) u_a (
        .clk(clk), .rst(rst_a), .in_data(in_data), .in_rs(in_rs), .in_valid(a_iv), .in_ready(a_in_ready),
        .backlight(backlight), .init_done(a_init_done), .busy(a_busy), .error(a_error),
        .cmd_address(a_addr), .cmd_start(a_start), .cmd_read(a_read), .cmd_write(a_write),
        .cmd_write_multiple(a_wm), .cmd_stop(a_stop), .cmd_valid(a_cv), .cmd_ready(cmd_ready),
        .data_tdata(a_td), .data_tvalid(a_tv), .data_tready(data_tready), .data_tlast(a_tl),
        .rd_tready(a_rdy), .prescale(a_pre), .stop_on_idle(a_soi), .i2c_busy(i2c_busy), .missed_ack(missed_ack)
    );

    lcd_i2c_seq #(.CLK_HZ(1000000), .PWRUP_US(B_PWRUP), .LONG_US(60), .SHORT_US(15)) u_b (
        .clk(clk), .rst(rst_b), .in_data(in_data), .in_rs(in_rs), .in_valid(b_iv), .in_ready(b_in_ready),
        .backlight(backlight), .init_done(b_init_done), .busy(b_busy), .error(b_error),
        .cmd_address(b_addr), .cmd_start(b_start), .cmd_read(b_read), .cmd_write(b_write),
        .cmd_write_multiple(b_wm), .cmd_stop(b_stop), .cmd_valid(b_cv), .cmd_ready(cmd_ready),
        .data_tdata(b_td), .data_tvalid(b_tv), .data_tready(data_tready), .data_tlast(b_tl),
        .rd_tready(b_rdy), .prescale(b_pre), .stop_on_idle(b_soi), .i2c_busy(i2c_busy), .missed_ack(missed_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int near(input int v, input int e, input int tol);
        return (v >= e - tol && v <= e + tol) ? e : v;
    endfunction

    function automatic logic sig(input int k);
        return k == 0 ? m_cmd_valid : k == 1 ? m_init_done : k == 2 ? m_in_ready : m_tvalid;
    endfunction

    task automatic wait_on(input int k, input int lim, input string tag);
        int t = 0;
        while (!sig(k) && t < lim) begin
            @(negedge clk);
            t++;
        end
        chk(tag, 32'(sig(k)), 32'd1);
    endtask

    // Responder standing in for i2c_master: random stalls, busy from command accept until after tlast.
    initial begin
        logic [8:0] pend;
        bit tpend, cpend;
        int hold;
        cmd_ready = 1'b0; data_tready = 1'b0; i2c_busy = 1'b0;
        hold = 0; tpend = 0; cpend = 0; pend = '0;
        forever begin
            @(negedge clk);
            if (!m_rst) begin
                i2c_busy = 1'b0; hold = 0; tpend = 0; cpend = 0;
            end else begin
                if (cpend) chk("cmd_valid_held", 32'(m_cmd_valid), 32'd1);
                if (tpend) chk("tdata_held", 32'({m_tvalid, m_tlast, m_tdata}), 32'({1'b1, pend}));
                cmd_ready   = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                data_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                cpend = m_cmd_valid && !cmd_ready;
                tpend = m_tvalid && !data_tready;
                pend  = {m_tlast, m_tdata};
                if (m_cmd_valid && cmd_ready) i2c_busy = 1'b1;
                if (m_tvalid && data_tready) begin
                    rx.push_back({m_tlast, m_tdata});
                    if (m_tlast) hold = $urandom_range(3, 15);
                end else if (hold > 0) begin
                    hold--;
                    if (hold == 0) begin
                        i2c_busy = 1'b0;
                        fall_cyc = cyc;
                    end
                end
            end
        end
    end

    task automatic load_init();
        for (int i = 0; i < 24; i++)
            exp_q.push_back({(i < 8) ? (i % 2 == 1) : (i % 4 == 3), init_exp[i]});
    endtask

    // One LCD byte: high nibble then low nibble, each strobed EN=1 then EN=0; tlast on the fourth.
    task automatic append_full(input logic [7:0] b, input logic rs, input logic bl);
        for (int h = 0; h < 2; h++)
            for (int e = 0; e < 2; e++) begin
                int n;
                n = (h == 0) ? int'(b) / 16 : int'(b) % 16;
                exp_q.push_back(9'(((h == 1 && e == 1) ? 256 : 0) + n * 16 + int'(bl) * 8 + (1 - e) * 4 + int'(rs)));
            end
    endtask

    task automatic cmp_stream(input string tag);
        chk({tag, "_len"}, 32'(rx.size() - ptr), 32'(exp_q.size()));
        foreach (exp_q[i])
            if (ptr + i < rx.size()) chk(tag, 32'(rx[ptr + i]), 32'(exp_q[i]));
        ptr = rx.size();
        exp_q.delete();
    endtask

    task automatic send(input logic [7:0] b, input logic rs, input logic bl, input logic mack);
        int dly;
        dly = (!rs && b >= 8'h01 && b <= 8'h03) ? A_LONG : A_SHORT;
        wait_on(2, 12000, "host_ready");
        backlight = bl; in_data = b; in_rs = rs; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("accept_to_cmd", 32'({m_cmd_valid, m_in_ready}), 32'd2);
        append_full(b, rs, bl);
        if (mack) begin
            wait_on(3, 200, "mack_window");
            missed_ack = 1'b1;
            @(negedge clk);
            missed_ack = 1'b0;
        end
        wait_on(2, 12000, "ready_return");
        chk("delay_len", 32'(near(cyc - fall_cyc, dly, 1)), 32'(dly));
        cmp_stream("stream");
    endtask

    initial begin
        int t0;
        rst_a = 1'b0; rst_b = 1'b0; sel = 1'b0; bp = 1'b0;
        in_valid = 1'b0; in_data = '0; in_rs = 1'b0; backlight = 1'b1; missed_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outs", 32'({m_cmd_valid, m_tvalid, m_tlast, m_in_ready, m_init_done, m_error, m_busy}), 32'd1);
        chk("const_outs", 32'({a_addr, a_start, a_read, a_write, a_wm, a_stop, a_soi, a_rdy}),
            32'({7'h27, 7'b0001101}));
        chk("prescale", 32'(a_pre), 32'd30);
        rst_a = 1'b1;
        t0 = cyc;
        wait_on(0, 60000, "first_cmd");
        chk("pwrup_lat", 32'(near(cyc - t0, A_PWRUP, 1)), 32'(A_PWRUP));
        wait_on(1, 20000, "init_done");
        chk("ready_after_init", 32'(m_in_ready), 32'd1);
        load_init();
        cmp_stream("init");
        send(8'h41, 1'b1, 1'b1, 1'b0);
        bp = 1'b1;
        send(8'h80, 1'b0, 1'b1, 1'b0);
        bp = 1'b0;
        send(8'h01, 1'b0, 1'b1, 1'b0);
        send(8'h80, 1'b0, 1'b1, 1'b0);
        send(8'h02, 1'b0, 1'b0, 1'b0);
        chk("err_clear", 32'(m_error), 32'd0);
        send(8'h55, 1'b1, 1'b1, 1'b1);
        chk("err_set", 32'(m_error), 32'd1);
        send(8'hA7, 1'b1, 1'b0, 1'b0);
        chk("err_sticky", 32'(m_error), 32'd1);
        for (int i = 0; i < 6; i++) begin
            bp = 1'($urandom_range(0, 1));
            send(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end
        sel = 1'b1; bp = 1'b0; backlight = 1'b1; ptr = rx.size();
        @(negedge clk);
        rst_b = 1'b1;
        t0 = cyc;
        wait_on(0, 2000, "b_first_cmd");
        chk("b_pwrup_lat", 32'(near(cyc - t0, B_PWRUP, 1)), 32'(B_PWRUP));
        wait_on(1, 5000, "b_init_done");
        load_init();
        cmp_stream("b_init");
        wait_on(2, 100, "b_ready");
        in_data = 8'h41; in_rs = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_on(3, 100, "b_in_data");
        rst_b = 1'b0;
        #1;
        chk("b_rst_async", 32'({m_cmd_valid, m_tvalid, m_tlast, m_in_ready, m_init_done, m_busy}), 32'd1);
        @(negedge clk);
        @(negedge clk);
        ptr = rx.size();
        rst_b = 1'b1;
        t0 = cyc;
        wait_on(0, 2000, "b_re_first_cmd");
        chk("b_re_pwrup_lat", 32'(near(cyc - t0, B_PWRUP, 1)), 32'(B_PWRUP));
        wait_on(1, 5000, "b_re_init_done");
        load_init();
        cmp_stream("b_reinit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/lcd_i2c_seq.md
# lcd_i2c_seq

Sequencer that drives the `i2c_master` AXI-stream command/data interface to operate an HD44780 character LCD behind a PCF8574 I2C expander in 4-bit mode. After reset it runs the LCD power-on initialisation autonomously. It then accepts one LCD byte at a time from a host valid/ready port and expands each byte into one 4-byte I2C write transaction, inserting the HD44780 execution delays. It sits between application logic and `i2c_master` inside the LCD top level.

## Interface
- `CLK_HZ`, 12000000, clock frequency; all delays derive from it.
- `DEV_ADDR`, 7'h27, PCF8574 7-bit address.
- `PRESCALE`, 16'd30, driven to `i2c_master` prescale (100 kHz SCL at 12 MHz).
- `PWRUP_US`, 50000, delay from reset release to the first transaction.
- `LONG_US`, 5000, delay after the first init nibble, and after commands 0x01, 0x02 and 0x03.
- `SHORT_US`, 100, delay after every other transaction.
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  LCD byte.
- `in_rs`  in  1  1 = character data, 0 = instruction.
- `in_valid` / `in_ready`  in/out  1  host handshake.
- `backlight`  in  1  PCF8574 P3 level, sampled when each I2C byte is built.
- `init_done`  out  1  high once initialisation completes; stays high until reset.
- `busy`  out  1  high whenever the state is not IDLE.
- `error`  out  1  sticky; set by any `missed_ack` pulse; cleared only by reset.
- `cmd_address` out 7, `cmd_start` out 1, `cmd_read` out 1, `cmd_write` out 1, `cmd_write_multiple` out 1, `cmd_stop` out 1, `cmd_valid` out 1, `cmd_ready` in 1: the `i2c_master` s_axis_cmd port.
- `data_tdata` out 8, `data_tvalid` out 1, `data_tready` in 1, `data_tlast` out 1: the `i2c_master` s_axis_data port.
- `rd_tready`  out  1  the `i2c_master` m_axis_data_tready; constant 1.
- `prescale` out 16, `stop_on_idle` out 1: `i2c_master` configuration.
- `i2c_busy`, `missed_ack`  in  1  from `i2c_master`.

## Operation
- **Constant outputs:**
  - `cmd_address`=DEV_ADDR, `cmd_write_multiple`=1, `cmd_stop`=1.
  - `cmd_start`=0, `cmd_read`=0, `cmd_write`=0, `stop_on_idle`=0.
  - `prescale`=PRESCALE.
- **Expander byte format:** {nibble[3:0], BL, EN, RW=0, RS}.
- **Full byte:** sent as 4 I2C bytes: hi|EN=1, hi|EN=0, lo|EN=1, lo|EN=0. `data_tlast` is asserted on the 4th byte.
- **Init nibble:** sent as 2 bytes: EN=1, EN=0, with `tlast` on the 2nd byte.
- **States:** PWRUP → INIT → IDLE → CMD → DATA → DRAIN → DELAY → (INIT or IDLE).
- **PWRUP:** counts PWRUP_US, then moves to INIT.
- **INIT sequence:**
  - nibble 3, LONG; nibble 3, SHORT; nibble 3, SHORT; nibble 2, SHORT.
  - byte 0x28, 0x0C, 0x06 (all RS=0), each SHORT.
  - byte 0x01, LONG.
  - Then set `init_done` and go to IDLE.
- **IDLE:** `in_ready`=1 only here, and only when `init_done`=1. On `in_valid & in_ready`, capture `in_data` and `in_rs`, then go to CMD.
- **CMD:** hold `cmd_valid`=1 until `cmd_ready`, then go to DATA.
- **DATA:** present bytes in order. Advance the byte index on `data_tvalid & data_tready`. After the last byte is accepted, drop `data_tvalid` and go to DRAIN.
- **DRAIN:** wait until `i2c_busy` has been seen high since command acceptance, and then is low.
- **DELAY:** count the selected delay (cycles = US·CLK_HZ/1e6, truncated; minimum 1), then go to the next state.
- **Delay selection:** LONG applies when RS=0 and the byte is 0x01, 0x02 or 0x03. Otherwise SHORT.
- **missed_ack:** sets `error`. The transaction still completes and sequencing continues unchanged.

## Timing
- **Reset values:**
  - 0: `cmd_valid`, `data_tvalid`, `data_tlast`, `in_ready`, `init_done`, `error`.
  - `busy`=1; the state is PWRUP.
- **Accept to command:** `cmd_valid` rises 1 cycle after the accept cycle.
- **Handshake stability:** `tdata`/`tlast` are stable while `tvalid & !tready`. `cmd_valid` never drops before `cmd_ready`.
- **Host throughput:** at most one host byte per transaction. `in_ready` returns 1 on the first IDLE cycle after DELAY expires.
- **Reset mid-transaction:** all outputs take their reset values immediately (asynchronous). Initialisation restarts from PWRUP.

## Test plan
- **Init sequence:** `CLK_HZ`=1000000, `backlight`=1, `tready` always 1, `i2c_master` model → first `cmd_valid` at cycle 50000 after reset release.
  - Data bytes: 3C 38, 3C 38, 3C 38, 2C 28.
  - Then 2C 28 8C 88, 0C 08 CC C8, 0C 08 6C 68, 0C 08 1C 18.
  - Then `init_done`=1.
- **Character write:** `in_data`=0x41, `in_rs`=1 → bytes 4D 49 1D 19; `tlast` only on 19; `in_ready` low until DELAY of 100 cycles ends.
- **Backpressure:** `data_tready` toggled at random during 0x80/RS=0 → byte stream exactly 8C 88 0C 08, values held while stalled, no byte dropped or duplicated.
- **Long vs short delay:** 0x01 vs 0x80 with RS=0 → `i2c_busy` fall to `in_ready` is 5000 vs 100 cycles (±1).
- **Missed ACK:** pulse `missed_ack` during a write → `error`=1, and it stays 1. The next host byte is still accepted and sent.
- **Reset mid-transaction:** assert `rst` during DATA → `cmd_valid`/`tvalid`/`init_done`=0 at once. After release, the full init sequence repeats.
